sync_ram: RTL and testbench
===========================

# sync_ram

Synchronous simple dual-port RAM with 16 words of 8 bits: one write port and one independent read port sharing a single clock. Used as a small register-file or scratch buffer wherever a write and a read to different (or equal) addresses must occur in the same cycle. Read data is registered, and the whole array clears on reset.

## Interface
Parameters:
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH (16)

Ports, in positional order data, w_addr, r_addr, clk, rst, we, re, out:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset; asynchronous, active-low
- data  input  DATA_WIDTH  write data
- w_addr  input  ADDR_WIDTH  write address
- r_addr  input  ADDR_WIDTH  read address
- we  input  1  write enable, active-high
- re  input  1  read enable, active-high
- out  output  DATA_WIDTH  registered read data

## Operation
- Reset (rst=0): every memory word is cleared to 0 and out is cleared to 0 immediately, without waiting for a clock edge. This holds while rst stays 0. All writes and reads are blocked during reset.
- Write: at a rising edge with rst=1 and we=1, mem[w_addr] <= data. With we=0, memory is unchanged.
- Read: at a rising edge with rst=1 and re=1, out <= mem[r_addr]. With re=0, out holds its last value.
- Collision: if we=1, re=1 and w_addr==r_addr at the same edge, out receives the new data (write-first bypass).
- Addresses are always in range, because DEPTH is 2**ADDR_WIDTH. No wrap or error logic is needed.
- Both ports operate fully independently. A write and a read to different addresses in the same cycle both take effect.

## Timing
- Write latency: data is stored at edge N and is readable by a read issued at edge N+1. It is also readable at edge N through the collision bypass.
- Read latency: 1 cycle. r_addr/re are sampled at edge N, and out is valid after edge N until the next enabled read or reset.
- Reset release: the first write or read takes effect at the first rising edge after rst returns to 1.
- Reset mid-operation: an asserted rst overrides any in-flight we/re. Stored contents are lost and out goes to 0.
- Inputs are expected to be stable around the rising edge. Benches drive inputs on the falling edge.

## Structure
- Shared package sync_ram_pkg holds the DATA_WIDTH and ADDR_WIDTH defaults, DEPTH, and a data word typedef.
- The design is a single module with no sub-module. It contains the memory array, the write process (async clear), and the read register process with bypass mux.

## Test plan
- Reset: pulse rst=0 then release. Read all 16 addresses with re=1; out must be 0x00 each cycle.
- Basic write/read: write data=0xA5 to w_addr=0xC with we=1. On the next cycle read r_addr=0xC with re=1; out must be 0xA5 one edge later.
- Enables: with we=0 and data=0xFF, w_addr=0x3, location 0x3 stays 0x00. Next, set re=0 after out=0xA5 and change r_addr to 0x3; out must stay 0xA5.
- Simultaneous ports: write 0x11 to 0x0 while reading 0xF, which was previously written as 0x5A. out must be 0x5A, and a later read of 0x0 must give 0x11.
- Collision: we=1, re=1, w_addr=r_addr=0x7, data=0x3C. out must be 0x3C after that same edge.
- Async reset mid-operation: after several writes, drive rst=0 between clock edges. out must go to 0x00 before the next edge, and every address must read 0x00 after release.

Source files
------------

// File: rtl/sync_ram_pkg.sv
// Shared defaults and word type for the 16x8 simple dual-port RAM.
package sync_ram_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 4;
  localparam int DEFAULT_DEPTH      = 1 << DEFAULT_ADDR_WIDTH;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] word_t;

endpackage : sync_ram_pkg

// File: rtl/sync_ram.sv
// Simple dual-port RAM: one write port, one registered read port, one clock.
// The whole array and the read register clear asynchronously while rst is low.
module sync_ram
  import sync_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] out
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [DATA_WIDTH-1:0] out_reg;
  logic [DATA_WIDTH-1:0] rd_next;
  logic                  bypass;

  // Clearing on reset rules out block RAM; the array maps to flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (we) begin
      mem_reg[w_addr] <= data;
    end
  end

  // Write-first: a same-address write in this cycle wins over stored data.
  assign bypass  = we && (w_addr == r_addr);
  assign rd_next = bypass ? data : mem_reg[r_addr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_reg <= '0;
    end else if (re) begin
      out_reg <= rd_next;
    end
  end

  assign out = out_reg;

endmodule : sync_ram

// File: tb/tb_sync_ram.sv
// Directed self-checking bench for sync_ram; inputs change on the falling edge,
// outputs are sampled 1 time unit after the rising edge.
module tb_sync_ram;
  import sync_ram_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  data;
  logic [3:0]  w_addr;
  logic [3:0]  r_addr;
  logic        we;
  logic        re;
  logic [7:0]  out;

  int n_cmp;
  int n_err;

  sync_ram dut (
    .data   (data),
    .w_addr (w_addr),
    .r_addr (r_addr),
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .re     (re),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of port values at the falling edge, then let the rising edge pass.
  task automatic step(input logic w_en, input logic [3:0] wa, input logic [7:0] wd,
                      input logic r_en, input logic [3:0] ra);
    @(negedge clk);
    we     = w_en;
    w_addr = wa;
    data   = wd;
    re     = r_en;
    r_addr = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    word_t exp;
    exp = 8'h00;
    rst = 1'b0;
    we = 1'b0; re = 1'b0; data = '0; w_addr = '0; r_addr = '0;
    #2;
    n_cmp++;
    if (out !== exp) begin
      n_err++;
      $display("FAIL reset_out: got %h expected %h", out, exp);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 4'h0, 8'h00, 1'b1, 4'(i));
      n_cmp++;
      if (out !== exp) begin
        n_err++;
        $display("FAIL reset_read[%0d]: got %h expected %h", i, out, exp);
      end
    end
    $display("test_reset: done");
  endtask

  task automatic test_basic();
    word_t exp;
    exp = 8'hA5;
    step(1'b1, 4'hC, 8'hA5, 1'b0, 4'h0);
    step(1'b1, 4'hF, 8'h5A, 1'b1, 4'hC);
    n_cmp++;
    if (out !== exp) begin
      n_err++;
      $display("FAIL basic_read_c: got %h expected %h", out, exp);
    end
    $display("test_basic: wrote C=A5 F=5A, read C -> %h", out);
  endtask

  task automatic test_enables();
    word_t exp;
    step(1'b0, 4'h3, 8'hFF, 1'b0, 4'h0);
    exp = 8'h00;
    step(1'b0, 4'h3, 8'hFF, 1'b1, 4'h3);
    n_cmp++;
    if (out !== exp) begin
      n_err++;
      $display("FAIL we_low_no_write: got %h expected %h", out, exp);
    end
    exp = 8'hA5;
    step(1'b0, 4'h0, 8'h00, 1'b1, 4'hC);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 4'h0, 8'h00, 1'b0, 4'h3);
      n_cmp++;
      if (out !== exp) begin
        n_err++;
        $display("FAIL re_low_hold[%0d]: got %h expected %h", i, out, exp);
      end
    end
    $display("test_enables: out held at %h", out);
  endtask

  task automatic test_simultaneous();
    word_t exp;
    exp = 8'h5A;
    step(1'b1, 4'h0, 8'h11, 1'b1, 4'hF);
    n_cmp++;
    if (out !== exp) begin
      n_err++;
      $display("FAIL simul_read_f: got %h expected %h", out, exp);
    end
    exp = 8'h11;
    step(1'b0, 4'h0, 8'h00, 1'b1, 4'h0);
    n_cmp++;
    if (out !== exp) begin
      n_err++;
      $display("FAIL simul_read_0: got %h expected %h", out, exp);
    end
    $display("test_simultaneous: read 0 -> %h", out);
  endtask

  task automatic test_collision();
    word_t exp;
    exp = 8'h3C;
    step(1'b1, 4'h7, 8'h3C, 1'b1, 4'h7);
    n_cmp++;
    if (out !== exp) begin
      n_err++;
      $display("FAIL collision_bypass: got %h expected %h", out, exp);
    end
    // Different addresses: no bypass, stored 7 is returned.
    step(1'b1, 4'h8, 8'hC3, 1'b1, 4'h7);
    n_cmp++;
    if (out !== exp) begin
      n_err++;
      $display("FAIL no_bypass_diff_addr: got %h expected %h", out, exp);
    end
    exp = 8'hC3;
    step(1'b0, 4'h0, 8'h00, 1'b1, 4'h8);
    n_cmp++;
    if (out !== exp) begin
      n_err++;
      $display("FAIL read_8: got %h expected %h", out, exp);
    end
    $display("test_collision: read 8 -> %h", out);
  endtask

  task automatic test_async_reset();
    word_t exp;
    step(1'b1, 4'h1, 8'h22, 1'b0, 4'h0);
    step(1'b1, 4'h2, 8'h33, 1'b1, 4'h1);
    exp = 8'h22;
    n_cmp++;
    if (out !== exp) begin
      n_err++;
      $display("FAIL pre_reset_read: got %h expected %h", out, exp);
    end
    @(negedge clk);
    rst = 1'b0;
    we = 1'b1; w_addr = 4'h1; data = 8'h99; re = 1'b1; r_addr = 4'h2;
    #2;
    exp = 8'h00;
    n_cmp++;
    if (out !== exp) begin
      n_err++;
      $display("FAIL async_clear_out: got %h expected %h", out, exp);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (out !== exp) begin
      n_err++;
      $display("FAIL reset_blocks_ops: got %h expected %h", out, exp);
    end
    @(negedge clk);
    rst = 1'b1;
    we = 1'b0; re = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 4'h0, 8'h00, 1'b1, 4'(i));
      n_cmp++;
      if (out !== exp) begin
        n_err++;
        $display("FAIL post_reset_read[%0d]: got %h expected %h", i, out, exp);
      end
    end
    $display("test_async_reset: done");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_enables();
    test_simultaneous();
    test_collision();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sync_ram
